// File: rtl/melody_sequencer.sv
// Melody sequencer: plays a 16-entry note table into the dds divider with articulation gaps and end-of-song loop/finish.
// Registered outputs, first note valid two edges after start; no backpressure, stop aborts at the next edge.
module melody_sequencer #(
   parameter int unsigned TICK_DIV = 500000,
   parameter int unsigned GAP_CYC  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       loop,
   input  logic       wr_en,
   input  logic [3:0] wr_addr,
   input  logic [6:0] wr_data,
   output logic [2:0] note_bin,
   output logic       note_on,
   output logic       busy,
   output logic       done,
   output logic [3:0] idx
);
   typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

   localparam logic [27:0] TICK_LOAD = 28'(TICK_DIV);
   localparam logic [27:0] GAP_LOAD  = 28'(GAP_CYC);
   localparam bit          HAS_GAP   = (GAP_CYC > 0);

   state_t      state_q, state_d;
   logic [27:0] cnt_q, cnt_d;
   logic [3:0]  idx_q, idx_d;
   logic [2:0]  note_bin_q, note_bin_d;
   logic        note_on_q, note_on_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [6:0]  note_tab_q [16];
   logic [6:0]  note_tab_d [16];
   logic [6:0]  entry;
   logic        advance;

   // Asynchronous read: a write landing on the same edge as a fetch is not seen by it.
   assign entry = note_tab_q[idx_q];

   always_comb begin
      note_tab_d = note_tab_q;
      if (wr_en) note_tab_d[wr_addr] = wr_data;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      note_bin_d = note_bin_q;
      note_on_d  = note_on_q;
      done_d     = 1'b0;
      advance    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FETCH;
               idx_d   = 4'd0;
            end
         end
         FETCH: begin
            if (entry[3:0] != 4'd0) begin
               note_bin_d = entry[6:4];
               note_on_d  = (entry[6:4] != 3'd0);
               cnt_d      = {24'd0, entry[3:0]} * TICK_LOAD;
               state_d    = PLAY;
            end else if (loop && idx_q != 4'd0) begin
               idx_d = 4'd0;
            end else begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         PLAY: begin
            cnt_d = cnt_q - 28'd1;
            if (cnt_q == 28'd1) begin
               note_on_d = 1'b0;
               if (HAS_GAP) begin
                  state_d = GAP;
                  cnt_d   = GAP_LOAD;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         GAP: begin
            cnt_d = cnt_q - 28'd1;
            if (cnt_q == 28'd1) advance = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // Running off the end of the table is treated like an end-of-song marker.
      if (advance) begin
         if (idx_q == 4'd15) begin
            if (loop) begin
               idx_d   = 4'd0;
               state_d = FETCH;
            end else begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end else begin
            idx_d   = idx_q + 4'd1;
            state_d = FETCH;
         end
      end

      if (stop) begin
         state_d    = IDLE;
         note_on_d  = 1'b0;
         done_d     = 1'b0;
         idx_d      = idx_q;
         note_bin_d = note_bin_q;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         note_bin_q <= '0;
         note_on_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         for (int i = 0; i < 16; i++) note_tab_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         note_bin_q <= note_bin_d;
         note_on_q  <= note_on_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         note_tab_q <= note_tab_d;
      end
   end

   assign note_bin = note_bin_q;
   assign note_on  = note_on_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign idx      = idx_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: per-cycle expected output traces built from the song timeline, compared as the DUT plays.
`timescale 1ns/1ps
module tb_melody_sequencer;
   localparam int TICK = 4;
   localparam int GAP  = 2;

   logic       clk = 1'b0;
   logic       rst, start, stop, loop, wr_en;
   logic [3:0] wr_addr;
   logic [6:0] wr_data;
   logic [2:0] note_bin;
   logic       note_on, busy, done;
   logic [3:0] idx;

   melody_sequencer #(.TICK_DIV(TICK), .GAP_CYC(GAP)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .note_bin(note_bin), .note_on(note_on), .busy(busy), .done(done), .idx(idx)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       on;
      logic [2:0] bin;
      logic       bz;
      logic       dn;
      logic [3:0] ix;
   } obs_t;

   typedef struct {
      logic [6:0] e0;
      logic [6:0] e1;
      logic [6:0] e2;
      int         exp_idx;
      int         exp_on;
   } vec_t;

   obs_t       exp_q[$];
   logic [6:0] tb_tab [16];
   logic [2:0] exp_bin;
   int         pass_cnt  = 0;
   int         total_cnt = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_int(input string name, input int got, input int want);
      total_cnt++;
      if (got == want) pass_cnt++;
      else $display("FAIL %s: got %0d, want %0d", name, got, want);
   endtask

   task automatic push(input logic on, input logic [2:0] bin, input logic bz, input logic dn, input logic [3:0] ix);
      exp_q.push_back({on, bin, bz, dn, ix});
   endtask

   task automatic write_entry(input logic [3:0] a, input logic [6:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
      tb_tab[a] = d;
   endtask

   // Expected non-loop song timeline: FETCH, dur*TICK note cycles, GAP silent cycles, next FETCH ... done, idle.
   task automatic push_song();
      logic [2:0] nb  = exp_bin;
      logic [3:0] i   = 4'd0;
      bit         fin = 1'b0;
      push(1'b0, nb, 1'b1, 1'b0, i);
      while (!fin) begin
         if (tb_tab[i][3:0] == 4'd0) begin
            push(1'b0, nb, 1'b0, 1'b1, i);
            fin = 1'b1;
         end else begin
            nb = tb_tab[i][6:4];
            repeat (int'(tb_tab[i][3:0]) * TICK) push(nb != 3'd0, nb, 1'b1, 1'b0, i);
            repeat (GAP) push(1'b0, nb, 1'b1, 1'b0, i);
            if (i == 4'd15) begin
               push(1'b0, nb, 1'b0, 1'b1, i);
               fin = 1'b1;
            end else begin
               i++;
               push(1'b0, nb, 1'b1, 1'b0, i);
            end
         end
      end
      push(1'b0, nb, 1'b0, 1'b0, i);
      exp_bin = nb;
   endtask

   task automatic run_sb(input string name, input int start2_at, input int stop_at, input int wr_at,
                         input logic [3:0] wa, input logic [6:0] wd, output int on_cnt);
      int   n = 0;
      obs_t want, got;
      on_cnt = 0;
      while (exp_q.size() > 0 && n < 4000) begin
         start   = (n == 0 || n == start2_at);
         stop    = (n == stop_at);
         wr_en   = (n == wr_at);
         wr_addr = wa;
         wr_data = wd;
         tick();
         start = 1'b0;
         stop  = 1'b0;
         wr_en = 1'b0;
         want  = exp_q.pop_front();
         got   = {note_on, note_bin, busy, done, idx};
         if (note_on) on_cnt++;
         total_cnt++;
         if (got == want) pass_cnt++;
         else $display("FAIL %s cyc %0d: got on=%0b bin=%0d busy=%0b done=%0b idx=%0d, want on=%0b bin=%0d busy=%0b done=%0b idx=%0d",
                       name, n, got.on, got.bin, got.bz, got.dn, got.ix, want.on, want.bin, want.bz, want.dn, want.ix);
         n++;
      end
      check_int({name, " queue drained"}, exp_q.size(), 0);
   endtask

   initial begin
      vec_t vecs [4];
      int   on_cnt;

      rst = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
      wr_en = 1'b0; wr_addr = 4'd0; wr_data = 7'd0;
      for (int k = 0; k < 16; k++) tb_tab[k] = 7'd0;
      exp_bin = 3'd0;

      vecs[0] = '{7'h00, 7'h00, 7'h00, 0, 0};
      vecs[1] = '{7'h32, 7'h51, 7'h00, 2, 12};
      vecs[2] = '{7'h32, 7'h03, 7'h00, 2, 8};
      vecs[3] = '{7'h73, 7'h00, 7'h00, 1, 12};

      repeat (3) tick();
      check_int("reset outputs", int'({note_on, note_bin, busy, done, idx}), 0);
      rst = 1'b1;
      tick();

      for (int v = 0; v < 4; v++) begin
         write_entry(4'd0, vecs[v].e0);
         write_entry(4'd1, vecs[v].e1);
         write_entry(4'd2, vecs[v].e2);
         push_song();
         run_sb($sformatf("vec%0d", v), -1, -1, -1, 4'd0, 7'd0, on_cnt);
         check_int($sformatf("vec%0d note_on cycles", v), on_cnt, vecs[v].exp_on);
         check_int($sformatf("vec%0d final idx", v), int'(idx), vecs[v].exp_idx);
      end

      // Loop back to entry 0 without done, then abort mid-note.
      write_entry(4'd0, 7'h32);
      write_entry(4'd1, 7'h51);
      write_entry(4'd2, 7'h00);
      loop = 1'b1;
      push(1'b0, exp_bin, 1'b1, 1'b0, 4'd0);
      repeat (8) push(1'b1, 3'd3, 1'b1, 1'b0, 4'd0);
      repeat (2) push(1'b0, 3'd3, 1'b1, 1'b0, 4'd0);
      push(1'b0, 3'd3, 1'b1, 1'b0, 4'd1);
      repeat (4) push(1'b1, 3'd5, 1'b1, 1'b0, 4'd1);
      repeat (2) push(1'b0, 3'd5, 1'b1, 1'b0, 4'd1);
      push(1'b0, 3'd5, 1'b1, 1'b0, 4'd2);
      push(1'b0, 3'd5, 1'b1, 1'b0, 4'd0);
      repeat (3) push(1'b1, 3'd3, 1'b1, 1'b0, 4'd0);
      push(1'b0, 3'd3, 1'b0, 1'b0, 4'd0);
      push(1'b0, 3'd3, 1'b0, 1'b0, 4'd0);
      run_sb("loop_stop", -1, 23, -1, 4'd0, 7'd0, on_cnt);
      check_int("loop_stop note_on cycles", on_cnt, 15);
      loop = 1'b0;
      exp_bin = 3'd3;

      // Rewrite e1 while e0 plays, then rewrite it on the very edge that fetches it.
      tb_tab[1] = 7'h71;
      push_song();
      run_sb("wr_during_play", -1, -1, 3, 4'd1, 7'h71, on_cnt);
      check_int("wr_during_play note_on cycles", on_cnt, 12);
      push_song();
      tb_tab[1] = 7'h21;
      run_sb("wr_at_fetch", -1, -1, 12, 4'd1, 7'h21, on_cnt);
      push_song();
      run_sb("after_fetch_wr", -1, -1, -1, 4'd0, 7'd0, on_cnt);

      // Full table: ends at the index wrap; a second start mid-song is ignored.
      for (int k = 0; k < 16; k++) write_entry(4'(k), 7'h11);
      push_song();
      run_sb("all16", 10, -1, -1, 4'd0, 7'd0, on_cnt);
      check_int("all16 note_on cycles", on_cnt, 64);
      check_int("all16 final idx", int'(idx), 15);

      rst = 1'b0;
      tick();
      check_int("mid-run reset outputs", int'({note_on, note_bin, busy, done, idx}), 0);
      rst = 1'b1;
      for (int k = 0; k < 16; k++) tb_tab[k] = 7'd0;
      exp_bin = 3'd0;
      push_song();
      run_sb("post_reset_empty", -1, -1, -1, 4'd0, 7'd0, on_cnt);
      check_int("post_reset_empty note_on cycles", on_cnt, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
